mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/tartaruga_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory-port arbiter: source ids, FSM states, bus word.
package tartaruga_pkg;

   typedef logic [31:0] bus32_t;

   typedef enum logic [1:0] {
      SRC_IF = 2'd0,
      SRC_LD = 2'd1,
      SRC_SB = 2'd2
   } mem_src_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } mem_arb_state_t;

   localparam int unsigned N_SRC = 3;

   // Priority ring order SB -> LD -> IF -> SB.
   function automatic mem_src_t next_src(input mem_src_t s);
      case (s)
         SRC_SB:  next_src = SRC_LD;
         SRC_LD:  next_src = SRC_IF;
         default: next_src = SRC_SB;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// One-hot request selector: first requester found walking the ring from i_ptr.
module mem_arb_pick
   import tartaruga_pkg::*;
(
   input  logic [N_SRC-1:0] i_req,
   input  mem_src_t         i_ptr,
   output logic [N_SRC-1:0] o_gnt
);

   mem_src_t w_cand;
   logic     w_done;

   always_comb begin
      o_gnt  = '0;
      w_done = 1'b0;
      w_cand = i_ptr;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!w_done && i_req[w_cand]) begin
            o_gnt[w_cand] = 1'b1;
            w_done        = 1'b1;
         end
         w_cand = next_src(w_cand);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of fetch, load and store-drain onto one memory port.
// Define MEM_ARB_RR_EN for round-robin selection; default is fixed SB > LD > IF.
module mem_port_arbiter
   import tartaruga_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                flush_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                ld_req_i,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   output logic                ld_gnt_o,
   output logic                ld_rvalid_o,
   output logic [DATA_W-1:0]   ld_rdata_o,
   input  logic                sb_req_i,
   input  logic [ADDR_W-1:0]   sb_addr_i,
   input  logic [DATA_W-1:0]   sb_wdata_i,
   input  logic [DATA_W/8-1:0] sb_be_i,
   output logic                sb_gnt_o,
   output logic                sb_done_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam int unsigned BE_W = DATA_W / 8;

   mem_arb_state_t    r_state;
   mem_src_t          r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_kill;

   logic [N_SRC-1:0]  w_req;
   logic [N_SRC-1:0]  w_pick;
   logic [N_SRC-1:0]  w_gnt;
   mem_src_t          w_ptr;
   mem_src_t          w_src;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [BE_W-1:0]   w_be;
   logic              w_resp;

   // A flushed fetch is not eligible in the same cycle; LD/SB still compete.
   assign w_req[SRC_IF] = if_req_i & ~flush_i;
   assign w_req[SRC_LD] = ld_req_i;
   assign w_req[SRC_SB] = sb_req_i;

`ifdef MEM_ARB_RR_EN
   mem_src_t r_ptr;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         r_ptr <= SRC_SB;
      else if (|w_gnt)
         r_ptr <= next_src(w_src);
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = SRC_SB;
`endif

   mem_arb_pick u_pick (
      .i_req (w_req),
      .i_ptr (w_ptr),
      .o_gnt (w_pick)
   );

   assign w_gnt = (r_state == IDLE) ? w_pick : '0;

   always_comb begin
      w_src   = SRC_IF;
      w_we    = 1'b0;
      w_addr  = if_addr_i;
      w_wdata = '0;
      w_be    = '1;
      if (w_gnt[SRC_SB]) begin
         w_src   = SRC_SB;
         w_we    = 1'b1;
         w_addr  = sb_addr_i;
         w_wdata = sb_wdata_i;
         w_be    = sb_be_i;
      end else if (w_gnt[SRC_LD]) begin
         w_src  = SRC_LD;
         w_addr = ld_addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
         r_owner <= SRC_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_kill  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_kill <= 1'b0;
               if (|w_gnt) begin
                  r_owner <= w_src;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_be    <= w_be;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (flush_i && r_owner == SRC_IF)
                  r_kill <= 1'b1;
               if (mem_gnt_i)
                  r_state <= WAIT_RESP;
            end
            WAIT_RESP: begin
               if (mem_rvalid_i) begin
                  r_kill  <= 1'b0;
                  r_state <= IDLE;
               end else if (flush_i && r_owner == SRC_IF) begin
                  r_kill <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_gnt_o = w_gnt[SRC_IF];
   assign ld_gnt_o = w_gnt[SRC_LD];
   assign sb_gnt_o = w_gnt[SRC_SB];

   assign mem_req_o   = (r_state == ISSUE);
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_be_o    = r_be;

   // A flush arriving together with the response must also suppress it.
   assign w_resp      = (r_state == WAIT_RESP) && mem_rvalid_i;
   assign if_rvalid_o = w_resp && (r_owner == SRC_IF) && !r_kill && !flush_i;
   assign ld_rvalid_o = w_resp && (r_owner == SRC_LD);
   assign sb_done_o   = w_resp && (r_owner == SRC_SB);
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign ld_rdata_o  = ld_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration table plus multi-cycle corner sequences.
module tb_mem_port_arbiter;

   localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

   logic        clk_i, rstn_i, flush_i;
   logic        if_req_i, if_gnt_o, if_rvalid_o;
   logic [31:0] if_addr_i, if_rdata_o;
   logic        ld_req_i, ld_gnt_o, ld_rvalid_o;
   logic [31:0] ld_addr_i, ld_rdata_o;
   logic        sb_req_i, sb_gnt_o, sb_done_o;
   logic [31:0] sb_addr_i, sb_wdata_i;
   logic [3:0]  sb_be_i;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   bit          gnt_en = 1'b1;
   bit          spur_rv = 1'b0;
   int unsigned mem_lat = 1;
   bit [31:0]   mem_q [bit [31:0]];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
      .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
      .sb_req_i(sb_req_i), .sb_addr_i(sb_addr_i), .sb_wdata_i(sb_wdata_i),
      .sb_be_i(sb_be_i), .sb_gnt_o(sb_gnt_o), .sb_done_o(sb_done_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   assign mem_gnt_i = gnt_en;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit [31:0] mem_read(input bit [31:0] a);
      return mem_q.exists(a) ? mem_q[a] : (a ^ RD_KEY);
   endfunction

   // Memory responder: accepts on handshake, answers mem_lat cycles after WAIT_RESP entry.
   initial begin
      int unsigned cnt;
      bit          hs, hs_we;
      bit [31:0]   hs_addr, hs_wd, pend, cur;
      bit [3:0]    hs_be;
      cnt = 0;
      pend = '0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         hs      = mem_req_o && mem_gnt_i && rstn_i;
         hs_we   = mem_we_o;
         hs_addr = mem_addr_o;
         hs_wd   = mem_wdata_o;
         hs_be   = mem_be_o;
         @(posedge clk_i);
         #2;
         mem_rvalid_i = spur_rv;
         mem_rdata_i  = spur_rv ? 32'hBAD0_BAD0 : '0;
         if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = pend;
            end
         end
         if (hs) begin
            if (hs_we) begin
               cur = mem_read(hs_addr);
               for (int b = 0; b < 4; b++)
                  if (hs_be[b]) cur[8*b +: 8] = hs_wd[8*b +: 8];
               mem_q[hs_addr] = cur;
               pend = '0;
            end else begin
               pend = mem_read(hs_addr);
            end
            cnt = mem_lat;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset;
      rstn_i = 1'b0;
      flush_i = 1'b0; if_req_i = 1'b0; ld_req_i = 1'b0; sb_req_i = 1'b0;
      spur_rv = 1'b0; gnt_en = 1'b1;
      tick;
      tick;
      rstn_i = 1'b1;
   endtask

   task automatic wait_gnt(input int unsigned budget, output logic [2:0] g);
      g = '0;
      for (int unsigned c = 0; c < budget; c++) begin
         @(negedge clk_i);
         if (sb_gnt_o | ld_gnt_o | if_gnt_o) begin
            g = {sb_gnt_o, ld_gnt_o, if_gnt_o};
            return;
         end
         tick;
      end
   endtask

   task automatic wait_resp(input int unsigned budget, output logic [2:0] resp,
                            output logic [31:0] data, output logic gnt_seen);
      resp = '0; data = '0; gnt_seen = 1'b0;
      for (int unsigned c = 0; c < budget; c++) begin
         @(negedge clk_i);
         if (sb_gnt_o | ld_gnt_o | if_gnt_o) gnt_seen = 1'b1;
         if (sb_done_o | ld_rvalid_o | if_rvalid_o) begin
            resp = {sb_done_o, ld_rvalid_o, if_rvalid_o};
            data = ld_rdata_o | if_rdata_o;
            tick;
            return;
         end
         tick;
      end
   endtask

   typedef struct {
      logic       sb, ld, ifr, fl;
      logic [2:0] exp_gnt;
   } vec_t;

   vec_t        vecs [12];
   logic [2:0]  g, resp;
   logic [31:0] data, expd;
   logic        gs;
   logic [2:0]  ord2 [3];
   logic [2:0]  ord3 [6];

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b100};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b100};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100};
      ord2 = '{3'b100, 3'b010, 3'b001};
`ifdef MEM_ARB_RR_EN
      ord3 = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
`else
      ord3 = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif

      rstn_i = 1'b0; flush_i = 1'b0;
      if_req_i = 1'b0; ld_req_i = 1'b0; sb_req_i = 1'b0;
      if_addr_i = '0; ld_addr_i = '0; sb_addr_i = '0; sb_wdata_i = '0; sb_be_i = '0;

      // Reset state
      @(negedge clk_i);
      chk("rst_ctl", {if_gnt_o, ld_gnt_o, sb_gnt_o, if_rvalid_o, ld_rvalid_o, sb_done_o,
                      mem_req_o, mem_we_o}, '0);
      chk("rst_bus", {mem_addr_o, mem_wdata_o}, '0);
      chk("rst_be_rdata", {mem_be_o, if_rdata_o | ld_rdata_o}, '0);
      do_reset;

      // Arbitration table, one transaction per vector from a fresh reset
      for (int i = 0; i < 12; i++) begin
         do_reset;
         sb_addr_i = 32'h300 + 32'(i) * 4; sb_wdata_i = 32'h1111_0000 + 32'(i); sb_be_i = 4'hF;
         ld_addr_i = 32'h400 + 32'(i) * 4;
         if_addr_i = 32'h500 + 32'(i) * 4;
         sb_req_i = vecs[i].sb; ld_req_i = vecs[i].ld; if_req_i = vecs[i].ifr; flush_i = vecs[i].fl;
         @(negedge clk_i);
         chk($sformatf("tbl%0d_gnt", i), {sb_gnt_o, ld_gnt_o, if_gnt_o}, vecs[i].exp_gnt);
         tick;
         sb_req_i = 1'b0; ld_req_i = 1'b0; if_req_i = 1'b0; flush_i = 1'b0;
         if (vecs[i].exp_gnt == 3'b000) begin
            @(negedge clk_i);
            chk($sformatf("tbl%0d_idle", i), mem_req_o, 1'b0);
         end else begin
            wait_resp(10, resp, data, gs);
            chk($sformatf("tbl%0d_resp", i), resp, vecs[i].exp_gnt);
            expd = vecs[i].exp_gnt[1] ? (ld_addr_i ^ RD_KEY) :
                   vecs[i].exp_gnt[0] ? (if_addr_i ^ RD_KEY) : 32'h0;
            chk($sformatf("tbl%0d_data", i), data, expd);
         end
      end

      // Spurious rvalid in IDLE, then single fetch with exact cycle timing
      do_reset;
      mem_lat = 1;
      mem_q[32'h100] = 32'h0050_0093;
      spur_rv = 1'b1;
      @(negedge clk_i);
      chk("idle_spur_rv", {sb_done_o, ld_rvalid_o, if_rvalid_o}, 3'b000);
      tick;
      spur_rv = 1'b0;
      if_addr_i = 32'h100; if_req_i = 1'b1;
      @(negedge clk_i);
      chk("f_c0_gnt", {if_gnt_o, mem_req_o}, 2'b10);
      tick;
      if_req_i = 1'b0;
      @(negedge clk_i);
      chk("f_c1_req", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h100});
      tick;
      @(negedge clk_i);
      chk("f_c2_norv", if_rvalid_o, 1'b0);
      tick;
      @(negedge clk_i);
      chk("f_c3_rv", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h0050_0093});
      chk("f_c3_ld_zero", {ld_rvalid_o, ld_rdata_o}, '0);
      tick;

      // SB, LD, IF simultaneous: store then load of the same word
      do_reset;
      sb_addr_i = 32'h200; sb_wdata_i = 32'hDEAD_BEEF; sb_be_i = 4'hF;
      ld_addr_i = 32'h200; if_addr_i = 32'h104;
      sb_req_i = 1'b1; ld_req_i = 1'b1; if_req_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(10, g);
         chk($sformatf("s2_gnt%0d", k), g, ord2[k]);
         tick;
         if (g[2]) sb_req_i = 1'b0;
         if (g[1]) ld_req_i = 1'b0;
         if (g[0]) if_req_i = 1'b0;
         @(negedge clk_i);
         if (k == 0)
            chk("s2_sb_bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                {2'b11, 32'h200, 32'hDEAD_BEEF, 4'hF});
         tick;
         wait_resp(10, resp, data, gs);
         chk($sformatf("s2_resp%0d", k), {gs, resp}, {1'b0, ord2[k]});
         if (k == 1) chk("s2_ld_data", data, 32'hDEAD_BEEF);
         if (k == 2) chk("s2_if_data", data, 32'h104 ^ RD_KEY);
      end

      // All three requesting continuously for six transactions
      do_reset;
      sb_addr_i = 32'h240; sb_wdata_i = 32'h0; ld_addr_i = 32'h244; if_addr_i = 32'h248;
      sb_req_i = 1'b1; ld_req_i = 1'b1; if_req_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_gnt(10, g);
         chk($sformatf("s3_gnt%0d", k), g, ord3[k]);
         tick;
         wait_resp(10, resp, data, gs);
         chk($sformatf("s3_resp%0d", k), {gs, resp}, {1'b0, ord3[k]});
      end
      sb_req_i = 1'b0; ld_req_i = 1'b0; if_req_i = 1'b0;

      // Flush during WAIT_RESP of a fetch
      do_reset;
      mem_lat = 3;
      if_addr_i = 32'h108; ld_addr_i = 32'h420; if_req_i = 1'b1;
      @(negedge clk_i);
      chk("fl_gnt", if_gnt_o, 1'b1);
      tick;
      if_req_i = 1'b0;
      tick;
      flush_i = 1'b1; ld_req_i = 1'b1;
      @(negedge clk_i);
      chk("fl_c2", {if_rvalid_o, ld_gnt_o}, 2'b00);
      tick;
      flush_i = 1'b0;
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk_i);
         chk($sformatf("fl_c%0d", c), {if_rvalid_o, ld_gnt_o, ld_rvalid_o}, 3'b000);
         tick;
      end
      @(negedge clk_i);
      chk("fl_c6_next_gnt", {ld_gnt_o, mem_req_o}, 2'b10);
      tick;
      ld_req_i = 1'b0;
      wait_resp(10, resp, data, gs);
      chk("fl_ld_resp", resp, 3'b010);
      if_addr_i = 32'h10C; if_req_i = 1'b1;
      wait_gnt(5, g);
      chk("fl_if2_gnt", g, 3'b001);
      tick;
      if_req_i = 1'b0;
      wait_resp(10, resp, data, gs);
      chk("fl_if2_resp", {resp, data}, {3'b001, 32'h10C ^ RD_KEY});

      // Memory stalls grant for five cycles; spurious rvalid while in ISSUE
      do_reset;
      mem_lat = 1; gnt_en = 1'b0;
      ld_addr_i = 32'h40C; ld_req_i = 1'b1;
      @(negedge clk_i);
      chk("st_gnt", ld_gnt_o, 1'b1);
      tick;
      ld_req_i = 1'b0;
      sb_addr_i = 32'h380; sb_req_i = 1'b1; if_req_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         spur_rv = (k == 2);
         @(negedge clk_i);
         chk($sformatf("st_hold%0d", k),
             {mem_req_o, mem_addr_o, sb_gnt_o, ld_gnt_o, if_gnt_o, ld_rvalid_o},
             {1'b1, 32'h40C, 4'b0000});
         tick;
      end
      spur_rv = 1'b0; sb_req_i = 1'b0; if_req_i = 1'b0; gnt_en = 1'b1;
      @(negedge clk_i);
      chk("st_still_issue", {mem_req_o, mem_addr_o}, {1'b1, 32'h40C});
      tick;
      wait_resp(10, resp, data, gs);
      chk("st_resp", {resp, data}, {3'b010, 32'h40C ^ RD_KEY});

      // Reset during WAIT_RESP of a load; late response must be dropped
      do_reset;
      mem_lat = 4;
      ld_addr_i = 32'h410; ld_req_i = 1'b1;
      @(negedge clk_i);
      chk("rm_gnt", ld_gnt_o, 1'b1);
      tick;
      ld_req_i = 1'b0;
      tick;
      rstn_i = 1'b0;
      @(negedge clk_i);
      chk("rm_in_rst", {ld_rvalid_o, mem_req_o}, 2'b00);
      tick;
      rstn_i = 1'b1;
      for (int c = 3; c <= 8; c++) begin
         @(negedge clk_i);
         chk($sformatf("rm_c%0d", c), {ld_rvalid_o, mem_req_o}, 2'b00);
         tick;
      end
      mem_lat = 1;
      if_addr_i = 32'h114; if_req_i = 1'b1;
      @(negedge clk_i);
      chk("rm_idle_gnt", if_gnt_o, 1'b1);
      tick;
      if_req_i = 1'b0;
      wait_resp(10, resp, data, gs);
      chk("rm_if_resp", {resp, data}, {3'b001, 32'h114 ^ RD_KEY});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
